ball_motion_ctl: RTL and testbench
==================================

Name: ball_motion_ctl

Overview:
- Per-frame game sequencer that owns the ball: stores ball position and direction, bounces the ball off the walls and pads, and detects misses.
- Keeps both scores and runs the IDLE/SERVE/PLAY/OVER game state machine.
- Drives x_ball/y_ball into the ball-and-pad draw stage.
- Advances once per frame, on the rising edge of the vblnk of the VGA timing stream.

Parameters:
- H_ACTIVE, 1024, visible width in pixels.
- V_ACTIVE, 768, visible height in pixels.
- BALL_SIZE, 15, ball extent minus 1; the ball occupies x..x+BALL_SIZE, y..y+BALL_SIZE.
- PAD_HEIGHT, 145, pad vertical extent minus 1.
- PAD_WIDTH, 15, pad horizontal extent minus 1.
- X_PAD_LEFT, 30, left pad left edge.
- X_PAD_RIGHT, 979, right pad left edge.
- BALL_SPEED, 4, pixels per frame on each axis.
- MAX_SPEED, 8, speed ceiling (used only with the optional feature).
- SERVE_DELAY, 60, frames the ball waits at centre before moving.
- WIN_SCORE, 9, score that ends the game.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- vblnk  in  1  vertical blank from the VGA timing stream
- start  in  1  level; starts a new game in IDLE or OVER
- y_pad_left  in  10  left pad top edge
- y_pad_right  in  10  right pad top edge
- x_ball  out  11  ball left edge
- y_ball  out  11  ball top edge
- score_left  out  4  left player score
- score_right  out  4  right player score
- game_state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 OVER
- pad_hit  out  1  one-cycle pulse on each pad bounce
- game_over  out  1  high while in OVER

Behaviour:
- Reset (async, rst=0), all outputs and registers:
  - x_ball=H_ACTIVE/2-BALL_SIZE/2 (505), y_ball=V_ACTIVE/2-BALL_SIZE/2 (377).
  - Scores 0, state IDLE, dx=right, dy=down, speed=BALL_SPEED, serve counter 0, pad_hit 0, vblnk_q 0.
  - Reset asserted mid-frame or mid-play aborts immediately; no partial update survives.
- Tick definition: vblnk registered into vblnk_q; tick = vblnk & ~vblnk_q. All state updates are registered at the edge ending the tick cycle, so outputs change one clock after vblnk is first sampled high. Exactly one tick per frame.
- IDLE/OVER: ball held at centre; ticks ignored. When start=1 on any cycle, the next edge clears the scores, loads serve counter 0, sets speed=BALL_SPEED and enters SERVE. start is ignored in SERVE and PLAY.
- SERVE: ball at centre. Each tick increments the counter. On the tick where counter==SERVE_DELAY-1, enter PLAY; no move on that tick.
- PLAY, each tick, y-axis and x-axis evaluated on the same tick from current values:
  - Y, moving down: if y+speed+BALL_SIZE >= V_ACTIVE-1, then y=V_ACTIVE-1-BALL_SIZE and dy=up; else y+=speed.
  - Y, moving up: if y<speed, then y=0 and dy=down; else y-=speed.
  - Left pad hit: moving left, x>X_PAD_LEFT+PAD_WIDTH, x-speed<=X_PAD_LEFT+PAD_WIDTH, and overlap (y+BALL_SIZE>=y_pad_left and y<=y_pad_left+PAD_HEIGHT). Result: x=X_PAD_LEFT+PAD_WIDTH+1, dx=right, pad_hit pulse.
  - Right pad hit (mirror): x+BALL_SIZE<X_PAD_RIGHT, x+speed+BALL_SIZE>=X_PAD_RIGHT, and overlap with y_pad_right. Result: x=X_PAD_RIGHT-BALL_SIZE-1, dx=left, pad_hit pulse.
  - Left miss: moving left, no hit, x<speed. score_right+1.
  - Right miss: moving right, no hit, x+speed+BALL_SIZE>H_ACTIVE-1. score_left+1.
  - Otherwise x moves by speed.
  - Overlap uses the pre-update y. A pad hit takes priority over a miss. Comparisons are done at 12 bits, with no wrap.
- Miss handling: ball returns to centre; dx points toward the player who conceded; dy is kept.
  - If the new score==WIN_SCORE, enter OVER.
  - Otherwise enter SERVE with counter 0.
- pad_hit is high for exactly one cycle, the cycle after the tick. Scores never exceed WIN_SCORE.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined: each pad hit sets speed=min(speed+1, MAX_SPEED), with the bounce itself computed using the old speed. speed is reloaded to BALL_SPEED on each serve and each new game.
- Undefined: speed stays BALL_SPEED; MAX_SPEED is unused.

Test Plan:
- Reset: rst=0 -> x_ball=505, y_ball=377, scores 0, game_state=00, pad_hit=0. Outputs are also correct when rst is released mid-frame.
- Serve: SERVE_DELAY=2, start pulse, then 2 vblnk rises -> game_state=10. Next tick -> x_ball=509, y_ball=381.
- Wall bounce: PLAY, dy=down, y=749 -> y=752, dy=up. Next tick -> y=748.
- Left pad hit: y_pad_left=300, ball x=48, y=350, moving left -> x=46, dx=right, pad_hit high 1 cycle. With y_pad_left=500 -> x=44, no hit.
- Miss/win: y_pad_left=0, ball x=2, y=600, moving left, score_right=8 -> score_right=9, game_state=11, game_over=1. Then start -> scores 0, SERVE. At score_right=3 the same miss gives 4, SERVE, dx=left.
- BALL_SPEEDUP_EN: 5 consecutive pad hits starting at speed 4 -> speed 5,6,7,8,8. Next serve -> speed 4.

Source files
------------

// File: rtl/ball_motion_ctl.sv
// Per-frame ball sequencer: ball position/direction, wall and pad bounces, misses, scores and game FSM.
// Optional BALL_SPEEDUP_EN: each pad hit raises the ball speed by one, up to MAX_SPEED.
module ball_motion_ctl #(
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned V_ACTIVE    = 768,
  parameter int unsigned BALL_SIZE   = 15,
  parameter int unsigned PAD_HEIGHT  = 145,
  parameter int unsigned PAD_WIDTH   = 15,
  parameter int unsigned X_PAD_LEFT  = 30,
  parameter int unsigned X_PAD_RIGHT = 979,
  parameter int unsigned BALL_SPEED  = 4,
  parameter int unsigned MAX_SPEED   = 8,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start,
  input  logic [9:0]  y_pad_left,
  input  logic [9:0]  y_pad_right,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic [1:0]  game_state,
  output logic        pad_hit,
  output logic        game_over
);

  localparam int unsigned SPD_TOP = (MAX_SPEED > BALL_SPEED) ? MAX_SPEED : BALL_SPEED;
  localparam int unsigned SPW     = $clog2(SPD_TOP + 1);
  localparam int unsigned CW      = $clog2(SERVE_DELAY + 1);

  localparam logic [10:0]    X_CTR     = 11'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [10:0]    Y_CTR     = 11'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [11:0]    L_BS      = 12'(BALL_SIZE);
  localparam logic [11:0]    L_PH      = 12'(PAD_HEIGHT);
  localparam logic [11:0]    L_Y_LIM   = 12'(V_ACTIVE - 1);
  localparam logic [11:0]    L_X_LIM   = 12'(H_ACTIVE - 1);
  localparam logic [11:0]    L_XL_EDGE = 12'(X_PAD_LEFT + PAD_WIDTH);
  localparam logic [11:0]    L_XR      = 12'(X_PAD_RIGHT);
  localparam logic [10:0]    Y_BOT     = 11'(V_ACTIVE - 1 - BALL_SIZE);
  localparam logic [10:0]    X_LHIT    = 11'(X_PAD_LEFT + PAD_WIDTH + 1);
  localparam logic [10:0]    X_RHIT    = 11'(X_PAD_RIGHT - BALL_SIZE - 1);
  localparam logic [SPW-1:0] SPD_INIT  = SPW'(BALL_SPEED);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SERVE_DELAY - 1);
  localparam logic [3:0]     WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SERVE = 2'b01,
    S_PLAY  = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [10:0]    x_q, x_d, y_q, y_d;
  logic           dx_q, dx_d, dy_q, dy_d;   // dx: 1 = right, dy: 1 = down
  logic [SPW-1:0] speed_q, speed_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     sl_q, sl_d, sr_q, sr_d;
  logic           hit_q, hit_d;
  logic           over_q;
  logic           vblnk_q;
  logic           tick;

  // 12-bit views so every comparison is free of wrap
  logic [11:0] xw, yw, spw, ypl, ypr;
  logic        y_floor, y_ceil, ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;
  logic [3:0]  sl_inc, sr_inc;

  assign tick = vblnk & ~vblnk_q;
  assign xw   = {1'b0, x_q};
  assign yw   = {1'b0, y_q};
  assign spw  = 12'(speed_q);
  assign ypl  = {2'b00, y_pad_left};
  assign ypr  = {2'b00, y_pad_right};

  assign y_floor = (yw + spw + L_BS) >= L_Y_LIM;
  assign y_ceil  = yw < spw;
  assign ov_l    = ((yw + L_BS) >= ypl) && (yw <= (ypl + L_PH));
  assign ov_r    = ((yw + L_BS) >= ypr) && (yw <= (ypr + L_PH));
  assign hit_l   = !dx_q && (xw > L_XL_EDGE) && ((xw - spw) <= L_XL_EDGE) && ov_l;
  assign hit_r   = dx_q && ((xw + L_BS) < L_XR) && ((xw + spw + L_BS) >= L_XR) && ov_r;
  assign miss_l  = !dx_q && !hit_l && (xw < spw);
  assign miss_r  = dx_q && !hit_r && ((xw + spw + L_BS) > L_X_LIM);
  assign sl_inc  = sl_q + 4'd1;
  assign sr_inc  = sr_q + 4'd1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= X_CTR;
      y_q     <= Y_CTR;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      speed_q <= SPD_INIT;
      cnt_q   <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      hit_q   <= 1'b0;
      over_q  <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      hit_q   <= hit_d;
      over_q  <= (state_d == S_OVER);
      vblnk_q <= vblnk;
    end
  end

  // Next-state and per-frame ball update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    hit_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        x_d = X_CTR;
        y_d = Y_CTR;
        if (start) begin
          sl_d    = '0;
          sr_d    = '0;
          cnt_d   = '0;
          speed_d = SPD_INIT;
          state_d = S_SERVE;
        end
      end

      S_SERVE: begin
        if (tick) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (tick) begin
          if (dy_q) begin
            if (y_floor) begin
              y_d  = Y_BOT;
              dy_d = 1'b0;
            end else begin
              y_d = 11'(yw + spw);
            end
          end else begin
            if (y_ceil) begin
              y_d  = '0;
              dy_d = 1'b1;
            end else begin
              y_d = 11'(yw - spw);
            end
          end

          if (hit_l || hit_r) begin
            x_d   = hit_l ? X_LHIT : X_RHIT;
            dx_d  = hit_l;
            hit_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
            if (speed_q < SPW'(MAX_SPEED)) speed_d = speed_q + SPW'(1);
`endif
          end else if (miss_l || miss_r) begin
            // Re-centre and serve toward whoever conceded; dy carries on
            x_d     = X_CTR;
            y_d     = Y_CTR;
            dx_d    = miss_r;
            cnt_d   = '0;
            speed_d = SPD_INIT;
            if (miss_l) sr_d = sr_inc;
            else        sl_d = sl_inc;
            state_d = ((miss_l ? sr_inc : sl_inc) == WIN) ? S_OVER : S_SERVE;
          end else begin
            x_d = dx_q ? 11'(xw + spw) : 11'(xw - spw);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign x_ball      = x_q;
  assign y_ball      = y_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign game_state  = state_q;
  assign pad_hit     = hit_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_ball_motion_ctl.sv
// Scoreboard bench for ball_motion_ctl: random frames/pads/start against a rule-level game model.
module tb_ball_motion_ctl;

  localparam int SERVE_DELAY = 2;
  localparam int BALL_SPEED  = 4;
  localparam int MAX_SPEED   = 8;
  localparam int WIN_SCORE   = 9;
  localparam int NCYC        = 60000;

  bit          clk;
  logic        rst;
  logic        vblnk;
  logic        start;
  logic [9:0]  y_pad_left;
  logic [9:0]  y_pad_right;
  logic [10:0] x_ball;
  logic [10:0] y_ball;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic [1:0]  game_state;
  logic        pad_hit;
  logic        game_over;

  ball_motion_ctl #(.SERVE_DELAY(SERVE_DELAY)) dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .start      (start),
    .y_pad_left (y_pad_left),
    .y_pad_right(y_pad_right),
    .x_ball     (x_ball),
    .y_ball     (y_ball),
    .score_left (score_left),
    .score_right(score_right),
    .game_state (game_state),
    .pad_hit    (pad_hit),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, sl, sr, st, hit, over;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n_hit = 0, n_miss = 0, n_over = 0, n_wall = 0;

  // Game model: st 0 idle, 1 serve, 2 play, 3 over; dx 1 right, dy 1 down
  int m_x, m_y, m_dx, m_dy, m_sp, m_cnt, m_sl, m_sr, m_st, m_hit, m_vq;

  function automatic void model_reset();
    m_x = 505; m_y = 377; m_dx = 1; m_dy = 1; m_sp = BALL_SPEED;
    m_cnt = 0; m_sl = 0; m_sr = 0; m_st = 0; m_hit = 0; m_vq = 0;
  endfunction

  function automatic void model_play(int ypl, int ypr);
    int ny, ndy;
    bit ovl, ovr, hl, hr, ml, mr;
    ndy = m_dy;
    if (m_dy == 1) begin
      if (m_y + m_sp + 15 >= 767) begin ny = 752; ndy = 0; n_wall++; end
      else ny = m_y + m_sp;
    end else begin
      if (m_y < m_sp) begin ny = 0; ndy = 1; n_wall++; end
      else ny = m_y - m_sp;
    end
    ovl = (m_y + 15 >= ypl) && (m_y <= ypl + 145);
    ovr = (m_y + 15 >= ypr) && (m_y <= ypr + 145);
    hl  = (m_dx == 0) && (m_x > 45) && (m_x - m_sp <= 45) && ovl;
    hr  = (m_dx == 1) && (m_x + 15 < 979) && (m_x + m_sp + 15 >= 979) && ovr;
    ml  = (m_dx == 0) && !hl && (m_x < m_sp);
    mr  = (m_dx == 1) && !hr && (m_x + m_sp + 15 > 1023);
    m_y  = ny;
    m_dy = ndy;
    if (hl || hr) begin
      m_x   = hl ? 46 : 963;
      m_dx  = hl ? 1 : 0;
      m_hit = 1;
      n_hit++;
`ifdef BALL_SPEEDUP_EN
      m_sp = (m_sp + 1 > MAX_SPEED) ? MAX_SPEED : m_sp + 1;
`endif
    end else if (ml || mr) begin
      n_miss++;
      m_x = 505; m_y = 377;
      m_dx = ml ? 0 : 1;
      if (ml) m_sr++; else m_sl++;
      m_cnt = 0; m_sp = BALL_SPEED;
      if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin m_st = 3; n_over++; end
      else m_st = 1;
    end else begin
      m_x = (m_dx == 1) ? m_x + m_sp : m_x - m_sp;
    end
  endfunction

  function automatic void model_step(bit vb, bit st, int ypl, int ypr);
    bit tick;
    tick  = vb && (m_vq == 0);
    m_vq  = vb;
    m_hit = 0;
    case (m_st)
      0, 3: if (st) begin
        m_sl = 0; m_sr = 0; m_cnt = 0; m_sp = BALL_SPEED; m_st = 1;
      end
      1: if (tick) begin
        m_cnt++;
        if (m_cnt == SERVE_DELAY) m_st = 2;
      end
      default: if (tick) model_play(ypl, ypr);
    endcase
  endfunction

  // Issue side: advance the model on every edge and queue the expected outputs
  always @(posedge clk) begin
    exp_t e;
    if (!rst) model_reset();
    else model_step(vblnk, start, int'(y_pad_left), int'(y_pad_right));
    e.x = m_x; e.y = m_y; e.sl = m_sl; e.sr = m_sr; e.st = m_st;
    e.hit = m_hit; e.over = (m_st == 3) ? 1 : 0;
    q.push_back(e);
  end

  // Check side: compare what the DUT presents against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t: no expected entry for DUT output", $time);
    end else begin
      e = q.pop_front();
      if (int'(x_ball) != e.x || int'(y_ball) != e.y || int'(score_left) != e.sl ||
          int'(score_right) != e.sr || int'(game_state) != e.st ||
          int'(pad_hit) != e.hit || int'(game_over) != e.over) begin
        errors++;
        $display("FAIL outputs t=%0t: got x=%0d y=%0d sl=%0d sr=%0d st=%0d hit=%0d over=%0d, want x=%0d y=%0d sl=%0d sr=%0d st=%0d hit=%0d over=%0d",
                 $time, x_ball, y_ball, score_left, score_right, game_state, pad_hit, game_over,
                 e.x, e.y, e.sl, e.sr, e.st, e.hit, e.over);
      end
    end
  end

  // Pad placement: often aligned near the ball (including overlap edges), otherwise anywhere
  function automatic logic [9:0] pad_pos();
    int v;
    if ($urandom_range(0, 3) == 0) v = m_y + 16 - int'($urandom_range(0, 163));
    else v = int'($urandom_range(0, 622));
    if (v < 0) v = 0;
    return 10'(v);
  endfunction

  initial begin
    int seg;
    rst = 1'b0; vblnk = 1'b0; start = 1'b0;
    y_pad_left = '0; y_pad_right = '0;
    seg = 0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      #1;
      if (seg == 0) begin
        vblnk = ~vblnk;
        seg = vblnk ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 3));
        if (!vblnk) begin
          y_pad_left  = pad_pos();
          y_pad_right = pad_pos();
        end
      end
      seg--;
      start = ($urandom_range(0, 39) == 0);
      // asynchronous reset in the middle of play, released mid-frame
      if (c == 25000) rst = 1'b0;
      if (c == 25003) rst = 1'b1;
    end
    @(negedge clk);
    #1;
    $display("info: pad_hits=%0d misses=%0d games_over=%0d wall_bounces=%0d",
             n_hit, n_miss, n_over, n_wall);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
